// File: rtl/rack_param_pkg.sv
// Shared definitions for the rack parameter path: slot indices, FSM states, default widths.
package rack_param_pkg;

    localparam int LCE      = 0;
    localparam int TAU      = 1;
    localparam int LTP      = 2;
    localparam int LTD      = 3;
    localparam int P_DELTA  = 4;
    localparam int SYN_GAIN = 5;
    localparam int CLK_DIV  = 6;
    localparam int SPARE    = 7;

    localparam int NPARAM_DEFAULT = 8;
    localparam int DW_DEFAULT     = 32;
    localparam int CW_DEFAULT     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/param_slot.sv
// One parameter slot: staging register, pending flag and committed value.
module param_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          trig,
    input  logic [DW-1:0] data_in,
    input  logic          commit,
    input  logic          def_req,
    input  logic [DW-1:0] default_val,
    output logic [DW-1:0] param_out,
    output logic          pending,
    output logic          overwrite_hit
);

    logic [DW-1:0] stage;

    assign overwrite_hit = trig & pending;

    // A trigger in the commit cycle wins over the clear, so it survives for the next tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage     <= '0;
            pending   <= 1'b0;
            param_out <= default_val;
        end else begin
            if (trig) begin
                stage <= data_in;
            end
            if (trig) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            if (commit) begin
                if (def_req) begin
                    param_out <= default_val;
                end else if (pending) begin
                    param_out <= stage;
                end
            end
        end
    end

endmodule

// File: rtl/param_commit_scheduler.sv
// Stages host parameter writes and commits them atomically on the next simulation tick.
module param_commit_scheduler #(
    parameter int NPARAM = 8,
    parameter int DW     = 32,
    parameter int CW     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NPARAM-1:0]    trig,
    input  logic [DW-1:0]        data_in,
    input  logic                 sim_tick,
    input  logic                 load_defaults,
    input  logic [NPARAM*DW-1:0] defaults_in,
    output logic [NPARAM*DW-1:0] param_out,
    output logic [NPARAM-1:0]    pending,
    output logic                 commit_pulse,
    output logic [CW-1:0]        commit_count,
    output logic                 overwrite,
    input  logic                 clear_flags
);

    import rack_param_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic              def_req;
    logic              commit;
    logic [NPARAM-1:0] ovw_hit;

    assign commit = (state == ARMED) && sim_tick;

    for (genvar k = 0; k < NPARAM; k++) begin : g_slot
        param_slot #(
            .DW (DW)
        ) u_slot (
            .clk           (clk),
            .reset_n       (reset_n),
            .trig          (trig[k]),
            .data_in       (data_in),
            .commit        (commit),
            .def_req       (def_req),
            .default_val   (defaults_in[k*DW +: DW]),
            .param_out     (param_out[k*DW +: DW]),
            .pending       (pending[k]),
            .overwrite_hit (ovw_hit[k])
        );
    end

    // Leaving COMMIT also considers same-cycle requests so a write landing in COMMIT is never stranded.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((|trig) || load_defaults) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (sim_tick) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                if ((|pending) || (|trig) || load_defaults || def_req) begin
                    state_nxt = ARMED;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            def_req      <= 1'b0;
            commit_pulse <= 1'b0;
            commit_count <= '0;
            overwrite    <= 1'b0;
        end else begin
            state        <= state_nxt;
            commit_pulse <= commit;
            if (commit) begin
                commit_count <= commit_count + CW'(1);
            end
            if (load_defaults) begin
                def_req <= 1'b1;
            end else if (commit) begin
                def_req <= 1'b0;
            end
            if (|ovw_hit) begin
                overwrite <= 1'b1;
            end else if (clear_flags) begin
                overwrite <= 1'b0;
            end
        end
    end

endmodule
